// File: rtl/tft_pkg.sv
// Shared TFT command constants, default panel geometry and decoder state codes
// used by the SPI sink (and its transmit-side peers).
package tft_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int DEFAULT_WIDTH  = 240;
    localparam int DEFAULT_HEIGHT = 320;

    // CASET(k)/PASET(k) share one state code each; k lives in a separate index.
    typedef logic [2:0] dec_state_t;
    localparam dec_state_t ST_IDLE     = 3'd0;
    localparam dec_state_t ST_CASET    = 3'd1;
    localparam dec_state_t ST_PASET    = 3'd2;
    localparam dec_state_t ST_RAMWR_HI = 3'd3;
    localparam dec_state_t ST_RAMWR_LO = 3'd4;

endpackage

// File: rtl/tft_spi_sink_if.sv
// Pin-level SPI inputs plus the decoded byte/pixel/window outputs of the sink.
interface tft_spi_sink_if;
  logic        tft_clk;
  logic        tft_mosi;
  logic        tft_dc;
  logic        tft_cs;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_dc;
  logic        pix_valid;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_rgb;
  logic [15:0] win_x0;
  logic [15:0] win_x1;
  logic [15:0] win_y0;
  logic [15:0] win_y1;
  logic        frame_err;

  modport master (
    output tft_clk, tft_mosi, tft_dc, tft_cs,
    input  byte_valid, byte_data, byte_dc, pix_valid, pix_x, pix_y, pix_rgb,
    input  win_x0, win_x1, win_y0, win_y1, frame_err
  );

  modport slave (
    input  tft_clk, tft_mosi, tft_dc, tft_cs,
    output byte_valid, byte_data, byte_dc, pix_valid, pix_x, pix_y, pix_rgb,
    output win_x0, win_x1, win_y0, win_y1, frame_err
  );
endinterface

// File: rtl/spi_byte_rx.sv
// Synchronizes the raw SPI pins into clk, shifts bits in on rising tft_clk and
// emits one byte strobe per 8 bits; partial bytes cut off by cs set frame_err.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tft_clk,
  input  logic       tft_mosi,
  input  logic       tft_dc,
  input  logic       tft_cs,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       frame_err
);

  logic [3:0] pin_raw;
  logic [3:0] pin_sync;

  assign pin_raw = {tft_cs, tft_dc, tft_mosi, tft_clk};

  // cs chain resets to 1 so the bus looks deselected until the pins propagate.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain_reg;
    always_ff @(posedge clk) begin
      if (rst) chain_reg <= (gi == 3) ? '1 : '0;
      else     chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_raw[gi]};
    end
    assign pin_sync[gi] = chain_reg[SYNC_STAGES-1];
  end

  logic       s_clk, s_mosi, s_dc, s_cs;
  logic       clk_prev_reg;
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt_reg;
  logic       byte_valid_reg, byte_dc_reg, frame_err_reg;
  logic [7:0] byte_data_reg;

  assign {s_cs, s_dc, s_mosi, s_clk} = pin_sync;

  always_ff @(posedge clk) begin
    byte_valid_reg <= 1'b0;
    if (rst) begin
      clk_prev_reg  <= 1'b0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      byte_data_reg <= '0;
      byte_dc_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      clk_prev_reg <= s_clk;
      if (s_cs) begin
        bit_cnt_reg <= '0;
        if (bit_cnt_reg != 3'd0) frame_err_reg <= 1'b1;
      end else if (s_clk && !clk_prev_reg) begin
        if (bit_cnt_reg == 3'd7) begin
          byte_valid_reg <= 1'b1;
          byte_data_reg  <= {shift_reg, s_mosi};
          byte_dc_reg    <= s_dc;
          bit_cnt_reg    <= '0;
        end else begin
          shift_reg   <= {shift_reg[5:0], s_mosi};
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
      end
    end
  end

  assign byte_valid = byte_valid_reg;
  assign byte_data  = byte_data_reg;
  assign byte_dc    = byte_dc_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: rtl/tft_spi_sink.sv
// TFT display-controller model: decodes CASET/PASET/RAMWR from the received
// byte stream into an address window and a stream of addressed RGB565 pixels.
module tft_spi_sink
  import tft_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int HEIGHT      = DEFAULT_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  tft_spi_sink_if.slave  bus
);

  localparam logic [15:0] WIDTH_L  = 16'(WIDTH);
  localparam logic [15:0] HEIGHT_L = 16'(HEIGHT);

  logic       rx_valid, rx_dc, rx_ferr;
  logic [7:0] rx_data;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .tft_clk    (bus.tft_clk),
    .tft_mosi   (bus.tft_mosi),
    .tft_dc     (bus.tft_dc),
    .tft_cs     (bus.tft_cs),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .byte_dc    (rx_dc),
    .frame_err  (rx_ferr)
  );

  dec_state_t  state_reg;
  logic [1:0]  idx_reg;
  logic [23:0] param_reg;
  logic [7:0]  hi_reg;
  logic [15:0] cx_reg, cy_reg;
  logic [15:0] win_x0_reg, win_x1_reg, win_y0_reg, win_y1_reg;
  logic        pix_valid_reg;
  logic [8:0]  pix_x_reg, pix_y_reg;
  logic [15:0] pix_rgb_reg;

  always_ff @(posedge clk) begin
    pix_valid_reg <= 1'b0;
    if (rst) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      param_reg   <= '0;
      hi_reg      <= '0;
      cx_reg      <= '0;
      cy_reg      <= '0;
      win_x0_reg  <= '0;
      win_x1_reg  <= WIDTH_L - 16'd1;
      win_y0_reg  <= '0;
      win_y1_reg  <= HEIGHT_L - 16'd1;
      pix_x_reg   <= '0;
      pix_y_reg   <= '0;
      pix_rgb_reg <= '0;
    end else if (rx_valid) begin
      if (!rx_dc) begin
        // Any command restarts decoding; half-collected parameters are dropped.
        idx_reg <= '0;
        case (rx_data)
          CMD_CASET: state_reg <= ST_CASET;
          CMD_PASET: state_reg <= ST_PASET;
          CMD_RAMWR: begin
            state_reg <= ST_RAMWR_HI;
            cx_reg    <= win_x0_reg;
            cy_reg    <= win_y0_reg;
          end
          default:   state_reg <= ST_IDLE;
        endcase
      end else begin
        case (state_reg)
          ST_CASET, ST_PASET: begin
            idx_reg   <= idx_reg + 2'd1;
            param_reg <= {param_reg[15:0], rx_data};
            if (idx_reg == 2'd3) begin
              if (state_reg == ST_CASET) begin
                win_x0_reg <= param_reg[23:8];
                win_x1_reg <= {param_reg[7:0], rx_data};
              end else begin
                win_y0_reg <= param_reg[23:8];
                win_y1_reg <= {param_reg[7:0], rx_data};
              end
              state_reg <= ST_IDLE;
            end
          end
          ST_RAMWR_HI: begin
            hi_reg    <= rx_data;
            state_reg <= ST_RAMWR_LO;
          end
          ST_RAMWR_LO: begin
            pix_valid_reg <= (cx_reg < WIDTH_L) && (cy_reg < HEIGHT_L);
            pix_x_reg     <= cx_reg[8:0];
            pix_y_reg     <= cy_reg[8:0];
            pix_rgb_reg   <= {hi_reg, rx_data};
            if (cx_reg >= win_x1_reg) begin
              cx_reg <= win_x0_reg;
              cy_reg <= (cy_reg >= win_y1_reg) ? win_y0_reg : cy_reg + 16'd1;
            end else begin
              cx_reg <= cx_reg + 16'd1;
            end
            state_reg <= ST_RAMWR_HI;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_valid = rx_valid;
  assign bus.byte_data  = rx_data;
  assign bus.byte_dc    = rx_dc;
  assign bus.frame_err  = rx_ferr;
  assign bus.pix_valid  = pix_valid_reg;
  assign bus.pix_x      = pix_x_reg;
  assign bus.pix_y      = pix_y_reg;
  assign bus.pix_rgb    = pix_rgb_reg;
  assign bus.win_x0     = win_x0_reg;
  assign bus.win_x1     = win_x1_reg;
  assign bus.win_y0     = win_y0_reg;
  assign bus.win_y1     = win_y1_reg;

endmodule

// File: tb/tb_tft_spi_sink.sv
// Drives bit-level SPI traffic into tft_spi_sink and compares bytes, pixels and
// window registers against a stream-level model of the display controller.
module tb_tft_spi_sink;
  import tft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tft_spi_sink_if bus();

  tft_spi_sink #(.WIDTH(240), .HEIGHT(320), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int x; int y; int rgb; } pix_t;

  int tests = 0;
  int fails = 0;

  logic [8:0] got_bytes[$];
  logic [8:0] exp_bytes[$];
  pix_t       got_pix[$];
  pix_t       exp_pix[$];
  pix_t       mon_p;

  // Stream-level model: current command, its collected data bytes, window.
  int         m_cmd;
  logic [7:0] m_par[$];
  int         mx0, mx1, my0, my1;
  bit         m_ferr;

  always @(negedge clk) begin
    if (bus.byte_valid) got_bytes.push_back({bus.byte_dc, bus.byte_data});
    if (bus.pix_valid) begin
      mon_p.x   = int'(bus.pix_x);
      mon_p.y   = int'(bus.pix_y);
      mon_p.rgb = int'(bus.pix_rgb);
      got_pix.push_back(mon_p);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mx0 = 0; mx1 = 239; my0 = 0; my1 = 319;
    m_cmd = -1;
    m_par.delete();
    m_ferr = 1'b0;
  endfunction

  // Pixel n of a RAMWR lands at raster position n inside the window (x0<=x1, y0<=y1).
  function automatic void model_byte(bit dc, logic [7:0] d);
    int n, w, h, x, y;
    pix_t p;
    if (!dc) begin
      m_par.delete();
      m_cmd = (d == CMD_CASET || d == CMD_PASET || d == CMD_RAMWR) ? int'(d) : -1;
    end else if (m_cmd == int'(CMD_CASET) || m_cmd == int'(CMD_PASET)) begin
      m_par.push_back(d);
      if (m_par.size() == 4) begin
        if (m_cmd == int'(CMD_CASET)) begin
          mx0 = {m_par[0], m_par[1]}; mx1 = {m_par[2], m_par[3]};
        end else begin
          my0 = {m_par[0], m_par[1]}; my1 = {m_par[2], m_par[3]};
        end
        m_cmd = -1;
        m_par.delete();
      end
    end else if (m_cmd == int'(CMD_RAMWR)) begin
      m_par.push_back(d);
      if (m_par.size() % 2 == 0) begin
        n = m_par.size() / 2 - 1;
        w = mx1 - mx0 + 1;
        h = my1 - my0 + 1;
        x = mx0 + n % w;
        y = my0 + (n / w) % h;
        if (x < 240 && y < 320) begin
          p.x = x; p.y = y; p.rgb = int'({m_par[m_par.size()-2], d});
          exp_pix.push_back(p);
        end
      end
    end
  endfunction

  task automatic spi_bit(input bit b, input bit dc);
    bus.tft_mosi = b;
    bus.tft_dc   = dc;
    #40 bus.tft_clk = 1'b1;
    #40 bus.tft_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit dc);
    for (int i = 7; i >= 0; i--) spi_bit(d[i], dc);
    exp_bytes.push_back({dc, d});
    model_byte(dc, d);
  endtask

  task automatic send_win(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
    send_byte(cmd, 1'b0);
    send_byte(s[15:8], 1'b1);
    send_byte(s[7:0], 1'b1);
    send_byte(e[15:8], 1'b1);
    send_byte(e[7:0], 1'b1);
  endtask

  task automatic send_pix(input logic [15:0] rgb);
    send_byte(rgb[15:8], 1'b1);
    send_byte(rgb[7:0], 1'b1);
  endtask

  task automatic cs_set(input bit v);
    bus.tft_cs = v;
    #50;
  endtask

  task automatic clear_queues();
    got_bytes.delete(); exp_bytes.delete();
    got_pix.delete();   exp_pix.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_queues();
  endtask

  task automatic compare_stream(input string tag);
    int nb, np;
    #100;
    check({tag, " nbytes"}, got_bytes.size(), exp_bytes.size());
    nb = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
    for (int i = 0; i < nb; i++)
      check($sformatf("%s byte%0d", tag, i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
    check({tag, " npix"}, got_pix.size(), exp_pix.size());
    np = (got_pix.size() < exp_pix.size()) ? got_pix.size() : exp_pix.size();
    for (int i = 0; i < np; i++) begin
      check($sformatf("%s pix%0d x", tag, i), got_pix[i].x, exp_pix[i].x);
      check($sformatf("%s pix%0d y", tag, i), got_pix[i].y, exp_pix[i].y);
      check($sformatf("%s pix%0d rgb", tag, i), got_pix[i].rgb, exp_pix[i].rgb);
    end
    $display("[TB] %s: %0d bytes, %0d pixels", tag, got_bytes.size(), got_pix.size());
    clear_queues();
  endtask

  task automatic check_window(input string tag);
    check({tag, " win_x0"}, bus.win_x0, mx0);
    check({tag, " win_x1"}, bus.win_x1, mx1);
    check({tag, " win_y0"}, bus.win_y0, my0);
    check({tag, " win_y1"}, bus.win_y1, my1);
    check({tag, " frame_err"}, bus.frame_err, m_ferr);
  endtask

  initial begin
    logic [15:0] x0, y0;
    bus.tft_clk = 1'b0; bus.tft_mosi = 1'b0; bus.tft_dc = 1'b0; bus.tft_cs = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst byte_valid", bus.byte_valid, 0);
    check("rst pix_valid", bus.pix_valid, 0);
    check("rst byte_data", bus.byte_data, 0);
    check("rst pix_xy", {bus.pix_x, bus.pix_y}, 0);
    check("rst pix_rgb", bus.pix_rgb, 0);
    check_window("rst");
    rst = 1'b0;
    @(negedge clk);
    cs_set(1'b0);

    send_win(CMD_CASET, 16'd10, 16'd12);
    compare_stream("caset");
    check("caset x0=10", bus.win_x0, 10);
    check("caset x1=12", bus.win_x1, 12);
    check_window("caset");

    send_win(CMD_PASET, 16'd5, 16'd6);
    send_byte(CMD_RAMWR, 1'b0);
    for (int i = 0; i < 7; i++) send_pix(16'hF800);
    #100;
    check("wrap npix", got_pix.size(), 7);
    if (got_pix.size() == 7) begin
      check("wrap last x", got_pix[6].x, 10);
      check("wrap last y", got_pix[6].y, 5);
      check("wrap last rgb", got_pix[6].rgb, 16'hF800);
    end
    compare_stream("ramwr wrap");
    check_window("ramwr wrap");

    do_reset();
    send_byte(CMD_CASET, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(CMD_RAMWR, 1'b0);
    send_pix(16'h1234);
    check("abort x1 kept", bus.win_x1, 239);
    compare_stream("caset abort");
    check_window("caset abort");

    send_win(CMD_CASET, 16'd238, 16'd241);
    send_byte(CMD_RAMWR, 1'b0);
    for (int i = 0; i < 4; i++) send_pix(16'(16'h0100 + i));
    #100;
    check("edge npix", got_pix.size(), 2);
    send_pix(16'hABCD);
    compare_stream("x edge");

    for (int i = 7; i >= 3; i--) spi_bit(CMD_RAMWR[i], 1'b0);
    cs_set(1'b1);
    m_ferr = 1'b1;
    compare_stream("cs abort");
    check_window("cs abort");
    cs_set(1'b0);
    send_byte(CMD_RAMWR, 1'b0);
    send_pix(16'h07E0);
    compare_stream("after abort");

    send_win(CMD_PASET, 16'd2, 16'd3);
    send_byte(CMD_RAMWR, 1'b0);
    send_byte(8'hF8, 1'b1);
    compare_stream("hi only");
    do_reset();
    send_byte(8'h1F, 1'b1);
    compare_stream("rst mid pixel");
    check_window("rst mid pixel");
    check("rst win_y1", bus.win_y1, 319);

    for (int it = 0; it < 12; it++) begin
      x0 = 16'($urandom_range(0, 250));
      y0 = 16'($urandom_range(0, 325));
      if (it % 4 == 0) begin
        send_byte(8'($urandom_range(0, 41)), 1'b0);
        send_byte(8'($urandom), 1'b1);
      end
      send_win(CMD_CASET, x0, x0 + 16'($urandom_range(0, 3)));
      send_win(CMD_PASET, y0, y0 + 16'($urandom_range(0, 2)));
      send_byte(CMD_RAMWR, 1'b0);
      for (int p = 0; p < int'($urandom_range(1, 10)); p++) send_pix(16'($urandom));
      compare_stream($sformatf("rand%0d", it));
      check_window($sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
